// File: rtl/ddr_tx_serializer.sv
// ddr_tx_serializer
//   Parallel-to-DDR gearbox. Takes WIDTH-bit words over a valid/ready handshake
//   into a one-word holding register, then shifts them out two bits per clock on
//   D0 (rising-edge bit) and D1 (falling-edge bit) toward a DDR output flop.
//   A word waiting in the holding register follows the current word with no gap.
//   Every output is a flop, so this block can sit right in front of the DDR flop.
//
// Parameters
//   WIDTH      word width, even and >= 4; one word takes WIDTH/2 beats
//   MSB_FIRST  1: beat j = {W[WIDTH-1-2j], W[WIDTH-2-2j]}; 0: beat j = {W[2j], W[2j+1]}
//   IDLE       level driven on D0/D1 while no word is being shifted
//
// Ports
//   C          clock
//   R          synchronous active-high reset
//   EN         shift enable; 0 freezes the shifter, the beat counter and D0/D1
//   DIN        parallel word, sampled only when DIN_VLD && DIN_RDY
//   DIN_VLD    DIN valid
//   DIN_RDY    holding register empty (registered, never depends on DIN_VLD)
//   D0, D1     rising / falling edge bit for the DDR flop
//   CE         DDR flop clock enable, EN delayed by one clock
//   BUSY       a word occupies the shifter
//   WORD_DONE  one-clock pulse alongside the last beat of each word

module ddr_tx_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE      = 1'b0
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VLD,
    output logic             DIN_RDY,
    output logic             D0,
    output logic             D1,
    output logic             CE,
    output logic             BUSY,
    output logic             WORD_DONE
);

    localparam int            BEATS     = WIDTH / 2;
    localparam int            CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    beat_cnt;
    logic             din_rdy_q;
    logic             d0_q;
    logic             d1_q;
    logic             ce_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             at_last;
    logic             drain;

    // The beat on the line is always taken from the head of the word, and the
    // word is then shifted so the next beat moves to the head.
    function automatic logic [1:0] head_beat(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-1], w[WIDTH-2]} : {w[0], w[1]};
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 2) : (w >> 2);
    endfunction

    assign accept  = DIN_VLD && din_rdy_q;
    assign at_last = (beat_cnt == LAST_BEAT);
    // HOLD moves into the shifter when the shifter is free at this edge: either
    // idle, or showing the last beat of its word (seamless back-to-back).
    assign drain   = EN && hold_full && ((state == S_IDLE) || at_last);

    always_ff @(posedge C) begin
        if (R) begin
            state     <= S_IDLE;
            hold_full <= 1'b0;
            beat_cnt  <= '0;
            din_rdy_q <= 1'b0;
            d0_q      <= IDLE;
            d1_q      <= IDLE;
            ce_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ce_q   <= EN;
            done_q <= 1'b0;

            // Ready for the next cycle is computed from next-cycle occupancy, so
            // a draining HOLD only reopens after the edge that empties it.
            din_rdy_q <= !(accept || (hold_full && !drain));

            // NOTE: hold and shreg are pure datapath and are left out of the
            // reset branch; hold_full and state say whether their contents mean
            // anything, so clearing them would only add reset fan-out.
            if (accept) begin
                hold      <= DIN;
                hold_full <= 1'b1;
            end else if (drain) begin
                hold_full <= 1'b0;
            end

            if (drain) begin
                {d0_q, d1_q} <= head_beat(hold);
                shreg        <= advance(hold);
                beat_cnt     <= '0;
                state        <= S_SHIFT;
                busy_q       <= 1'b1;
            end else if (EN && (state == S_SHIFT)) begin
                if (at_last) begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    d0_q   <= IDLE;
                    d1_q   <= IDLE;
                end else begin
                    {d0_q, d1_q} <= head_beat(shreg);
                    shreg        <= advance(shreg);
                    beat_cnt     <= beat_cnt + ONE;
                    done_q       <= ((beat_cnt + ONE) == LAST_BEAT);
                end
            end
        end
    end

    assign DIN_RDY   = din_rdy_q;
    assign D0        = d0_q;
    assign D1        = d1_q;
    assign CE        = ce_q;
    assign BUSY      = busy_q;
    assign WORD_DONE = done_q;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Bench for ddr_tx_serializer. Two instances share every input: one MSB-first
// with idle level 0, one LSB-first with idle level 1. Accepted words are
// expanded into per-beat expectations and queued; a negedge monitor pops one
// beat whenever the previous edge had EN=1 and a queued word is eligible.
module tb_ddr_tx_serializer;

    localparam int         W      = 8;
    localparam int         N      = W / 2;
    localparam logic [1:0] IDLE_M = 2'b00;
    localparam logic [1:0] IDLE_L = 2'b11;

    logic         C = 1'b0;
    logic         R;
    logic         EN;
    logic [W-1:0] DIN;
    logic         DIN_VLD;

    logic rdy_m, d0_m, d1_m, ce_m, busy_m, done_m;
    logic rdy_l, d0_l, d1_l, ce_l, busy_l, done_l;

    ddr_tx_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE(1'b0)) dut_m (
        .C(C), .R(R), .EN(EN), .DIN(DIN), .DIN_VLD(DIN_VLD), .DIN_RDY(rdy_m),
        .D0(d0_m), .D1(d1_m), .CE(ce_m), .BUSY(busy_m), .WORD_DONE(done_m)
    );

    ddr_tx_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE(1'b1)) dut_l (
        .C(C), .R(R), .EN(EN), .DIN(DIN), .DIN_VLD(DIN_VLD), .DIN_RDY(rdy_l),
        .D0(d0_l), .D1(d1_l), .CE(ce_l), .BUSY(busy_l), .WORD_DONE(done_l)
    );

    always #5 C = ~C;

    typedef struct {
        logic [1:0] pm;     // expected {D0,D1}, MSB-first instance
        logic [1:0] pl;     // expected {D0,D1}, LSB-first instance
        bit         last;   // last beat of its word
        int         avail;  // first edge count at which this word may be on the line
    } beat_t;

    beat_t sb[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pcyc     = 0;
    logic r_q      = 1'b1;
    logic en_q     = 1'b0;

    always @(posedge C) begin
        pcyc <= pcyc + 1;
        r_q  <= R;
        en_q <= EN;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge C);
        #1;
    endtask

    // Expand a word accepted at the coming edge into its beats. The earliest
    // edge that can show its first beat is the one after the accepting edge.
    task automatic push(input logic [W-1:0] w);
        beat_t e;
        for (int j = 0; j < N; j++) begin
            e.pm    = {w[W-1-2*j], w[W-2-2*j]};
            e.pl    = {w[2*j], w[2*j+1]};
            e.last  = (j == N - 1);
            e.avail = pcyc + 2;
            sb.push_back(e);
        end
    endtask

    // Monitor
    beat_t      mon_e;
    logic [1:0] last_m    = IDLE_M;
    logic [1:0] last_l    = IDLE_L;
    logic       last_busy = 1'b0;

    always @(negedge C) begin
        if (pcyc > 0) begin
            if (r_q) begin
                check("rst_d_msb", {d0_m, d1_m}, IDLE_M);
                check("rst_d_lsb", {d0_l, d1_l}, IDLE_L);
                check("rst_ce",    {ce_m, ce_l}, 2'b00);
                check("rst_busy",  {busy_m, busy_l}, 2'b00);
                check("rst_rdy",   {rdy_m, rdy_l}, 2'b00);
                check("rst_done",  {done_m, done_l}, 2'b00);
                last_m    = IDLE_M;
                last_l    = IDLE_L;
                last_busy = 1'b0;
            end else begin
                check("ce", {ce_m, ce_l}, {2{en_q}});
                if (en_q) begin
                    if (sb.size() > 0 && sb[0].avail <= pcyc) begin
                        mon_e = sb.pop_front();
                        check("beat_busy",  {busy_m, busy_l}, 2'b11);
                        check("beat_d_msb", {d0_m, d1_m}, mon_e.pm);
                        check("beat_d_lsb", {d0_l, d1_l}, mon_e.pl);
                        check("beat_done",  {done_m, done_l}, {2{mon_e.last}});
                        last_m    = mon_e.pm;
                        last_l    = mon_e.pl;
                        last_busy = 1'b1;
                    end else begin
                        check("idle_busy",  {busy_m, busy_l}, 2'b00);
                        check("idle_d_msb", {d0_m, d1_m}, IDLE_M);
                        check("idle_d_lsb", {d0_l, d1_l}, IDLE_L);
                        check("idle_done",  {done_m, done_l}, 2'b00);
                        last_m    = IDLE_M;
                        last_l    = IDLE_L;
                        last_busy = 1'b0;
                    end
                end else begin
                    check("hold_d_msb", {d0_m, d1_m}, last_m);
                    check("hold_d_lsb", {d0_l, d1_l}, last_l);
                    check("hold_busy",  {busy_m, busy_l}, {2{last_busy}});
                    check("hold_done",  {done_m, done_l}, 2'b00);
                end
            end
        end
    end

    // Offer a word with DIN_VLD held until it is taken; DIN carries junk while
    // DIN_RDY is low. Returns just after the accepting edge with DIN_VLD still 1.
    task automatic send(input logic [W-1:0] w);
        bit taken = 1'b0;
        DIN_VLD = 1'b1;
        for (int i = 0; i < 32 && !taken; i++) begin
            if (rdy_m) begin
                DIN = w;
                push(w);
                taken = 1'b1;
            end else begin
                DIN = W'($urandom);
            end
            tick();
        end
        check("send_accepted", {31'd0, taken}, 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        DIN_VLD = 1'b0;
        EN      = 1'b1;
        while (sb.size() != 0 && k < 64) begin
            tick();
            k++;
        end
        tick();
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        R       = 1'b1;
        DIN_VLD = 1'b0;
        sb.delete();
        tick();
        check("rst_rdy_low", {rdy_m, rdy_l}, 2'b00);
        tick();
        R = 1'b0;
        tick();
        check("rst_rdy_high", {rdy_m, rdy_l}, 2'b11);
        check("rst_release_idle", {d0_m, d1_m, d0_l, d1_l, busy_m}, {IDLE_M, IDLE_L, 1'b0});
    endtask

    logic [1:0] b4_m [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] b4_l [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    initial begin
        R       = 1'b1;
        EN      = 1'b1;
        DIN_VLD = 1'b0;
        DIN     = '0;
        tick();

        // Reset
        do_reset();

        // Single word, both bit orders, with first-beat latency
        send(8'hB4);
        DIN_VLD = 1'b0;
        check("t2_not_yet_busy", busy_m, 1'b0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("t2_msb_pair", {d0_m, d1_m}, b4_m[j]);
            check("t2_lsb_pair", {d0_l, d1_l}, b4_l[j]);
            check("t2_done", done_m, (j == 3));
        end
        tick();
        check("t2_after_idle", {d0_m, d1_m, d0_l, d1_l, busy_m}, {IDLE_M, IDLE_L, 1'b0});

        // Back-to-back words with DIN_VLD held
        send(8'hFF);
        check("t3_rdy_low_full", rdy_m, 1'b0);
        send(8'h00);
        DIN_VLD = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t3_rdy_low_waiting", rdy_m, 1'b0);
            tick();
        end
        check("t3_rdy_after_drain", rdy_m, 1'b1);
        drain();

        // EN pause at beat 1, second word accepted during the pause
        send(8'hB4);
        DIN_VLD = 1'b0;
        tick();
        check("t4_beat0", {d0_m, d1_m}, 2'b10);
        tick();
        check("t4_beat1", {d0_m, d1_m}, 2'b11);
        EN      = 1'b0;
        DIN     = 8'h5A;
        DIN_VLD = 1'b1;
        check("t4_rdy_in_pause", rdy_m, 1'b1);
        push(DIN);
        for (int k = 0; k < 3; k++) begin
            tick();
            DIN_VLD = 1'b0;
            check("t4_frozen_pair", {d0_m, d1_m}, 2'b11);
            check("t4_ce_low", ce_m, 1'b0);
            check("t4_hold_taken", rdy_m, 1'b0);
        end
        EN = 1'b1;
        tick();
        check("t4_resume_beat2", {d0_m, d1_m, ce_m}, {2'b01, 1'b1});
        tick();
        check("t4_resume_beat3", {d0_m, d1_m, done_m}, {2'b00, 1'b1});
        tick();
        check("t4_next_word", {busy_m, d0_m, d1_m}, {1'b1, 2'b01});
        drain();

        // Reset at beat 2 with HOLD full: both words discarded
        send(8'hC3);
        send(8'h3C);
        DIN_VLD = 1'b0;
        tick();
        check("t6_mid_word", {busy_m, rdy_m, d0_m, d1_m}, {1'b1, 1'b0, 2'b00});
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t6_stays_idle", {busy_m, d0_m, d1_m}, {1'b0, IDLE_M});
        end
        send(8'h96);
        drain();

        // Randomised traffic, EN gaps and one reset in the middle
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset();
            EN      = ($urandom_range(0, 3) != 0);
            DIN     = W'($urandom);
            DIN_VLD = 1'($urandom_range(0, 1));
            if (DIN_VLD && rdy_m) push(DIN);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
